// File: rtl/seq_fp_divider_if.sv
// seq_fp_divider_if -- operand/result bus of the sequential FP divider.
//
// Signals:
//   in_valid  producer -> divider  operands present
//   in_ready  divider  -> producer divider can accept operands
//   input_a   producer -> divider  dividend {sign, exp, mantissa}
//   input_b   producer -> divider  divisor  {sign, exp, mantissa}
//   out_valid divider  -> consumer result present
//   out_ready consumer -> divider  consumer accepts result
//   output_z  divider  -> consumer quotient
//   busy      divider  -> anyone   divider is not idle
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A source holds its payload stable while valid is high and ready
// is low; ready may be asserted independently of valid.
//
// Modports: slave = the divider, master = whoever drives operands and
// consumes results.

interface seq_fp_divider_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] input_a;
   logic [W-1:0] input_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] output_z;
   logic         busy;

   modport slave (
      input  in_valid, input_a, input_b, out_ready,
      output in_ready, out_valid, output_z, busy
   );

   modport master (
      output in_valid, input_a, input_b, out_ready,
      input  in_ready, out_valid, output_z, busy
   );
endinterface

// File: rtl/seq_fp_divider.sv
// seq_fp_divider -- multi-cycle IEEE-754-style floating-point divider.
//
// Computes output_z = input_a / input_b with a radix-2 restoring divider,
// one quotient bit per clock, followed by round-to-nearest-even. Subnormal
// inputs are treated as zero and subnormal results are flushed to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        seq_fp_divider_if.slave (operand/result handshakes, busy)
//   dbg_state  current FSM state (IDLE=0 UNPACK=1 DIVIDE=2 ROUND=3 DONE=4)
//   flags      {invalid, div_by_zero, overflow, underflow}, valid with
//              out_valid; present only when FP_DIV_FLAGS_EN is defined
//
// Optional feature macro: FP_DIV_FLAGS_EN (adds the flags port).
//
// Latency from the accepting edge to out_valid: MAN_W+5 edges for normal
// operands, 2 edges for special operands.

module seq_fp_divider #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_fp_divider_if.slave   bus,
`ifdef FP_DIV_FLAGS_EN
   output logic [3:0]        flags,
`endif
   output logic [2:0]        dbg_state
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int QW = MAN_W + 3;          // quotient bits, weights 2^0..2^-(MAN_W+2)
   localparam int CW = $clog2(QW);
   localparam int EW = EXP_W + 2;          // signed working exponent width
   localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_ZERO = '0;
   localparam logic [CW-1:0]        LAST   = CW'(QW - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         a_q, a_d, b_q, b_d, z_q, z_d;
   logic [MAN_W+1:0]     rem_q, rem_d;
   logic [MAN_W:0]       dvs_q, dvs_d;
   logic [QW-1:0]        quo_q, quo_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic signed [EW-1:0] e_q, e_d;

   // Operand classification on the registered operands (held until IDLE).
   logic sign_z, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic sp_invalid, sp_dbz, is_special;
   logic [W-1:0] spec_res;

   assign sign_z = a_q[W-1] ^ b_q[W-1];
   assign a_zero = ~|a_q[W-2:MAN_W];
   assign b_zero = ~|b_q[W-2:MAN_W];
   assign a_nan  = (&a_q[W-2:MAN_W]) & (|a_q[MAN_W-1:0]);
   assign b_nan  = (&b_q[W-2:MAN_W]) & (|b_q[MAN_W-1:0]);
   assign a_inf  = (&a_q[W-2:MAN_W]) & ~(|a_q[MAN_W-1:0]);
   assign b_inf  = (&b_q[W-2:MAN_W]) & ~(|b_q[MAN_W-1:0]);

   assign sp_invalid = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
   // inf/0 is an exact infinity, not a division by zero.
   assign sp_dbz     = ~sp_invalid & ~a_inf & b_zero;
   assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign spec_res   = sp_invalid       ? QNAN :
                       (a_inf | sp_dbz) ? {sign_z, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                          {sign_z, {(W-1){1'b0}}};

   // One restoring-division step.
   logic             rem_ge;
   logic [MAN_W+1:0] rem_sub;
   assign rem_ge  = rem_q >= {1'b0, dvs_q};
   assign rem_sub = rem_ge ? rem_q - {1'b0, dvs_q} : rem_q;

   // Normalise and round the finished quotient.
   logic [MAN_W:0]       sig;
   logic                 grd, stk, rnd_up;
   logic [MAN_W+1:0]     sig_rnd;
   logic signed [EW-1:0] e_adj, e_fin;
   logic [MAN_W-1:0]     man_fin;
   logic                 ovf, unf;
   logic [W-1:0]         norm_res;

   always_comb begin
      if (quo_q[QW-1]) begin
         sig   = quo_q[QW-1:2];
         grd   = quo_q[1];
         stk   = quo_q[0] | (|rem_q);
         e_adj = e_q;
      end else begin
         // Quotient below 1: the bit below the guard shifts up into it.
         sig   = quo_q[QW-2:1];
         grd   = quo_q[0];
         stk   = |rem_q;
         e_adj = e_q - E_ONE;
      end
      rnd_up  = grd & (stk | sig[0]);
      sig_rnd = {1'b0, sig} + {{(MAN_W+1){1'b0}}, rnd_up};
      if (sig_rnd[MAN_W+1]) begin
         man_fin = sig_rnd[MAN_W:1];
         e_fin   = e_adj + E_ONE;
      end else begin
         man_fin = sig_rnd[MAN_W-1:0];
         e_fin   = e_adj;
      end
      ovf = e_fin >= E_MAX;
      unf = e_fin <= E_ZERO;
      if (ovf)      norm_res = {sign_z, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (unf) norm_res = {sign_z, {(W-1){1'b0}}};
      else          norm_res = {sign_z, e_fin[EXP_W-1:0], man_fin};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      z_d     = z_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      e_d     = e_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.input_a;
               b_d     = bus.input_b;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            // Specials skip DIVIDE; ROUND forwards spec_res so every result
            // is registered from the same state.
            if (is_special) begin
               state_d = ROUND;
            end else begin
               rem_d   = {1'b0, 1'b1, a_q[MAN_W-1:0]};
               dvs_d   = {1'b1, b_q[MAN_W-1:0]};
               quo_d   = '0;
               cnt_d   = '0;
               e_d     = $signed({2'b00, a_q[W-2:MAN_W]}) -
                         $signed({2'b00, b_q[W-2:MAN_W]}) + BIAS;
               state_d = DIVIDE;
            end
         end
         DIVIDE: begin
            rem_d = {rem_sub[MAN_W:0], 1'b0};
            quo_d = {quo_q[QW-2:0], rem_ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = ROUND;
         end
         ROUND: begin
            z_d     = is_special ? spec_res : norm_res;
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         z_q     <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         e_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         z_q     <= z_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
      end
   end

`ifdef FP_DIV_FLAGS_EN
   logic [3:0] flags_q, flags_d;

   always_comb begin
      flags_d = flags_q;
      if (state_q == ROUND) begin
         if (is_special) flags_d = {sp_invalid, sp_dbz, 2'b00};
         else            flags_d = {2'b00, ovf, unf};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

   assign flags = flags_q;
`endif

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.output_z  = z_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_seq_fp_divider.sv
// tb_seq_fp_divider -- self-checking bench for seq_fp_divider (binary32).
// Expected results come from an integer long-division reference model with
// explicit round-to-nearest-even; a queue holds expected quotients in order.

module tb_seq_fp_divider;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] dbg_state;
`ifdef FP_DIV_FLAGS_EN
   logic [3:0] flags;
`endif
   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   seq_fp_divider_if #(.W(32)) bus ();

   seq_fp_divider #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
`ifdef FP_DIV_FLAGS_EN
      .flags     (flags),
`endif
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // ---------------- reference model ----------------
   // Exact quotient of the 24-bit significands scaled by 2^39, then RNE.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] z, output logic [3:0] fl,
                                   output int lat);
      logic s;
      int ea, eb, e;
      bit an, bn, ai, bi, az, bz, up;
      longint unsigned num, den, q, r, keep, rest, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      az = (ea == 0);
      bz = (eb == 0);
      lat = 2;
      fl  = 4'b0000;
      if (an || bn || (az && bz) || (ai && bi)) begin z = 32'h7FC00000; fl = 4'b1000; return; end
      if (ai) begin z = {s, 8'hFF, 23'h0}; return; end
      if (bi) begin z = {s, 31'h0}; return; end
      if (bz) begin z = {s, 8'hFF, 23'h0}; fl = 4'b0100; return; end
      if (az) begin z = {s, 31'h0}; return; end
      lat = 28;
      num = {40'd0, 1'b1, a[22:0]};
      num = num << 39;
      den = {40'd0, 1'b1, b[22:0]};
      q = num / den;
      r = num % den;
      e = ea - eb + 127;
      if (q >= (64'd1 << 39)) begin
         keep = q >> 16; rest = q & 64'hFFFF; half = 64'h8000;
      end else begin
         e = e - 1;
         keep = q >> 15; rest = q & 64'h7FFF; half = 64'h4000;
      end
      up = (rest > half) || ((rest == half) && ((r != 0) || keep[0]));
      if (up) keep = keep + 1;
      if (keep == (64'd1 << 24)) begin keep = keep >> 1; e = e + 1; end
      if (e >= 255)    begin z = {s, 8'hFF, 23'h0}; fl = 4'b0010; end
      else if (e <= 0) begin z = {s, 31'h0};        fl = 4'b0001; end
      else             z = {s, e[7:0], keep[22:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        output int lat_e, output logic [3:0] fl_e);
      logic [31:0] z_e;
      int n;
      ref_div(a, b, z_e, fl_e, lat_e);
      exp_q.push_back(z_e);
      n = 0;
      while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
      check("in_ready before issue", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.input_a  = a;
      bus.input_b  = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic await_result(input string tag, input int lat_e, input logic [3:0] fl_e);
      int n;
      n = 0;
      while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check({tag, " latency"}, 32'(n), 32'(lat_e));
      check({tag, " z"}, bus.output_z, exp_q.pop_front());
`ifdef FP_DIV_FLAGS_EN
      check({tag, " flags"}, {28'b0, flags}, {28'b0, fl_e});
`endif
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
      int lat_e;
      logic [3:0] fl_e;
      bus.out_ready = 1'b1;
      issue(a, b, lat_e, fl_e);
      await_result(tag, lat_e, fl_e);
      @(posedge clk); #1;
      check({tag, " in_ready after"}, {31'b0, bus.in_ready}, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] ra, rb, z_ref;
   logic [3:0]  fl_e;
   int          lat_e;

   initial begin
      bus.in_valid  = 1'b0;
      bus.input_a   = '0;
      bus.input_b   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("reset output_z",  bus.output_z,           32'd0);
      check("reset busy",      {31'b0, bus.busy},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      run_op(32'h40C00000, 32'h40000000, "6/2");
      run_op(32'h3F800000, 32'h40400000, "1/3");
      run_op(32'h3F800000, 32'h00000000, "1/0");
      run_op(32'h00000000, 32'h00000000, "0/0");
      run_op(32'h7F7FFFFF, 32'h00800000, "overflow");
      run_op(32'h00800000, 32'h7F7FFFFF, "underflow");
      run_op(32'h7F800000, 32'hC0000000, "inf/-2");
      run_op(32'h40000000, 32'hFF800000, "2/-inf");
      run_op(32'h7F800000, 32'h7F800000, "inf/inf");
      run_op(32'h7FA00000, 32'h3F800000, "nan/1");
      run_op(32'h80000000, 32'h40400000, "-0/3");
      run_op(32'h3F800000, 32'h3F7FFFFF, "1/max_below_1");

      // Backpressure: result held, new operands ignored while DONE
      bus.out_ready = 1'b0;
      ra = 32'h40200000;
      rb = 32'h3F000000;
      ref_div(ra, rb, z_ref, fl_e, lat_e);
      issue(ra, rb, lat_e, fl_e);
      await_result("bp", lat_e, fl_e);
      bus.in_valid = 1'b1;
      bus.input_a  = 32'h3F800000;
      bus.input_b  = 32'h40000000;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp hold z",         bus.output_z,            z_ref);
         check("bp hold in_ready",  {31'b0, bus.in_ready},  32'd0);
         check("bp hold out_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("bp release out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("bp release busy",      {31'b0, bus.busy},      32'd0);

      // Reset in the middle of DIVIDE discards the operation
      issue(32'h40C00000, 32'h40000000, lat_e, fl_e);
      repeat (10) @(posedge clk);
      #1;
      check("mid busy", {31'b0, bus.busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("mid rst in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("mid rst busy",      {31'b0, bus.busy},      32'd0);
      check("mid rst output_z",  bus.output_z,           32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h40C00000, 32'h40000000, "6/2 after reset");

      // Randomized operands, mostly finite with a few fully random words
      for (int i = 0; i < 30; i++) begin
         ra = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
         rb = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
         if (i % 10 == 9) begin
            ra = $urandom;
            rb = $urandom;
         end
         run_op(ra, rb, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
